// File: rtl/pixel_shift_reg_pkg.sv
// ---------------------------------------------------------------------------
// pixel_shift_reg_pkg
// Shared types for the LED-protocol receive pipeline.
//   shift_reg_input_t : per-bit output of the pulse decoder
//                       {decode_bit, valid, treset}
//   pixel_t           : one GRB pixel word, green in the top byte
//   fwd_output_t      : daisy-chain output {bit_val, valid}
//   pixel_state_e     : capture / forward state of pixel_shift_reg
// ---------------------------------------------------------------------------
package pixel_shift_reg_pkg;

  localparam int PIXEL_BITS_DEFAULT = 24;

  typedef struct packed {
    logic decode_bit;
    logic valid;
    logic treset;
  } shift_reg_input_t;

  localparam shift_reg_input_t RESET_VALUES_SHIFT_REG = '{
    decode_bit: 1'b0, valid: 1'b0, treset: 1'b0
  };

  typedef struct packed {
    logic [7:0] green;
    logic [7:0] red;
    logic [7:0] blue;
  } pixel_t;

  // "bit" is a reserved word, so the data field is named bit_val.
  typedef struct packed {
    logic bit_val;
    logic valid;
  } fwd_output_t;

  localparam fwd_output_t RESET_VALUES_FWD = '{bit_val: 1'b0, valid: 1'b0};

  typedef enum logic {
    CAPTURE = 1'b0,
    FORWARD = 1'b1
  } pixel_state_e;

endpackage

// File: rtl/pixel_shift_reg.sv
// ---------------------------------------------------------------------------
// pixel_shift_reg
// Final stage of the LED receive pipeline. After a reset gap (treset) the
// first PIXEL_BITS decoded bits are assembled MSB first into one pixel word;
// every later bit of the frame is forwarded on the daisy-chain output.
// All outputs are registered, one cycle after the accepted input.
//
// Ports:
//   clk          pipeline clock
//   reset        synchronous, active-high reset
//   shift_in     {decode_bit, valid, treset} from the pulse decoder
//   pixel_data   last completed pixel word, held until the next completion
//   pixel_valid  one-cycle pulse when pixel_data updates
//   fwd_bit      forwarded bit value
//   fwd_valid    one-cycle pulse qualifying fwd_bit
//   frame_error  one-cycle pulse when treset cuts off a partial pixel
//   busy         high while capturing with at least one bit taken
//
// CNT_W must satisfy 2**CNT_W > PIXEL_BITS; PIXEL_BITS must be >= 3.
// ---------------------------------------------------------------------------
module pixel_shift_reg
  import pixel_shift_reg_pkg::*;
#(
  parameter int PIXEL_BITS = PIXEL_BITS_DEFAULT,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  shift_reg_input_t      shift_in,
  output logic [PIXEL_BITS-1:0] pixel_data,
  output logic                  pixel_valid,
  output logic                  fwd_bit,
  output logic                  fwd_valid,
  output logic                  frame_error,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PIXEL_BITS - 1);

  pixel_state_e          state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  // Only PIXEL_BITS-1 bits are ever held before completion; the final bit
  // is appended directly when the word is published.
  logic [PIXEL_BITS-2:0] acc, acc_next;
  logic [PIXEL_BITS-1:0] data_next;
  logic                  pv_next;
  fwd_output_t           fwd, fwd_next;
  logic                  fe_next;
  logic                  busy_next;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    acc_next   = acc;
    data_next  = pixel_data;
    pv_next    = 1'b0;
    fwd_next   = '{bit_val: fwd.bit_val, valid: 1'b0};
    fe_next    = 1'b0;

    if (shift_in.treset) begin
      // treset wins over a coincident valid bit; pixel_data is kept.
      fe_next    = (state == CAPTURE) && (cnt != '0);
      state_next = CAPTURE;
      cnt_next   = '0;
      acc_next   = '0;
    end else if (shift_in.valid) begin
      unique case (state)
        CAPTURE: begin
          if (cnt == LAST_CNT) begin
            data_next  = {acc, shift_in.decode_bit};
            pv_next    = 1'b1;
            cnt_next   = '0;
            acc_next   = '0;
            state_next = FORWARD;
          end else begin
            acc_next = {acc[PIXEL_BITS-3:0], shift_in.decode_bit};
            cnt_next = cnt + CNT_W'(1);
          end
        end
        FORWARD: begin
          fwd_next = '{bit_val: shift_in.decode_bit, valid: 1'b1};
        end
        default: ;
      endcase
    end

    busy_next = (state_next == CAPTURE) && (cnt_next != '0);
  end

  // ---- register stage: state and all outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CAPTURE;
      cnt         <= '0;
      acc         <= '0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      fwd         <= RESET_VALUES_FWD;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      acc         <= acc_next;
      pixel_data  <= data_next;
      pixel_valid <= pv_next;
      fwd         <= fwd_next;
      frame_error <= fe_next;
      busy        <= busy_next;
    end
  end

  assign fwd_bit   = fwd.bit_val;
  assign fwd_valid = fwd.valid;

endmodule

// File: tb/tb_pixel_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_pixel_shift_reg
// Directed frame scenarios followed by randomized traffic, all checked each
// cycle against a frame-level reference model of the pixel receiver.
// ---------------------------------------------------------------------------
module tb_pixel_shift_reg;
  import pixel_shift_reg_pkg::*;

  localparam int PB = 24;

  logic             clk = 1'b0;
  logic             reset;
  shift_reg_input_t shift_in;
  logic [PB-1:0]    pixel_data;
  logic             pixel_valid, fwd_bit, fwd_valid, frame_error, busy;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: a frame either still gathers its first pixel (a list
  // of bits so far) or has finished it and forwards everything else.
  bit            m_forwarding;
  bit            m_bits[$];
  logic [PB-1:0] m_pixel;
  bit            e_pv, e_fv, e_fb, e_fe, e_busy;

  pixel_shift_reg #(.PIXEL_BITS(PB), .CNT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .shift_in    (shift_in),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .fwd_bit     (fwd_bit),
    .fwd_valid   (fwd_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit b, input bit v, input bit t, input bit r);
    logic [PB-1:0] w;
    e_pv = 0; e_fv = 0; e_fe = 0;
    if (r) begin
      m_forwarding = 0;
      m_bits.delete();
      m_pixel = '0;
      e_fb    = 0;
    end else if (t) begin
      e_fe = !m_forwarding && (m_bits.size() > 0);
      m_forwarding = 0;
      m_bits.delete();
    end else if (v) begin
      if (m_forwarding) begin
        e_fv = 1;
        e_fb = b;
      end else begin
        m_bits.push_back(b);
        if (m_bits.size() == PB) begin
          w = '0;
          foreach (m_bits[i]) w = w * 2 + PB'(m_bits[i]);
          m_pixel = w;
          e_pv = 1;
          m_bits.delete();
          m_forwarding = 1;
        end
      end
    end
    e_busy = !m_forwarding && (m_bits.size() > 0);
  endtask

  // One clock: apply inputs, update model, check all outputs after the edge.
  task automatic drive(input bit b, input bit v, input bit t, input bit r);
    reset    = r;
    shift_in = '{decode_bit: b, valid: v, treset: t};
    @(posedge clk);
    #1;
    model_step(b, v, t, r);
    chk("pixel_valid", 32'(pixel_valid), 32'(e_pv));
    chk("pixel_data", 32'(pixel_data), 32'(m_pixel));
    chk("fwd_valid", 32'(fwd_valid), 32'(e_fv));
    if (e_fv || r) chk("fwd_bit", 32'(fwd_bit), 32'(e_fb));
    chk("frame_error", 32'(frame_error), 32'(e_fe));
    chk("busy", 32'(busy), 32'(e_busy));
    reset    = 1'b0;
    shift_in = RESET_VALUES_SHIFT_REG;
  endtask

  task automatic send_word(input logic [PB-1:0] w);
    for (int i = PB - 1; i >= 0; i--) drive(w[i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    shift_in = RESET_VALUES_SHIFT_REG;

    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // First pixel, then 48 forwarded alternating bits.
    send_word(24'hA5C3F0);
    chk("pixel_word_1", 32'(pixel_data), 32'h00A5C3F0);
    for (int i = 0; i < 48; i++) drive(((i % 2) == 0), 1'b1, 1'b0, 1'b0);
    idle(1);

    // New frame.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    send_word(24'h123456);
    chk("pixel_word_2", 32'(pixel_data), 32'h00123456);

    // Partial pixel cut by treset, then a clean word.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("partial_error", 32'(frame_error), 32'd1);
    send_word(24'hFFFFFF);
    chk("pixel_word_3", 32'(pixel_data), 32'h00FFFFFF);

    // valid and treset together at counter 0, back-to-back with the word.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("drop_no_error", 32'(frame_error), 32'd0);
    send_word(24'h000001);
    chk("pixel_word_4", 32'(pixel_data), 32'h00000001);

    // valid and treset together mid-pixel: counts as a partial.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a pixel, then a full word.
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    chk("reset_data", 32'(pixel_data), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(24'h5A5A5A);
    chk("pixel_word_5", 32'(pixel_data), 32'h005A5A5A);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int unsigned p;
      bit b, v, t, r;
      p = $urandom_range(0, 999);
      b = 1'($urandom);
      v = ($urandom_range(0, 99) < 75);
      t = (p < 25);
      r = (p >= 995);
      drive(b, v, t, r);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
